// File: rtl/orb_pkg.sv
// Shared constants and enumerations for the orbit-RAM FIFO scheduler.
//   DW/AW/UW : word, RAM address and FIFO fill-level widths
//   chanT    : FIFO channel index in drain-priority order
//   stateT   : drain sequencer states
package orb_pkg;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 11;
    localparam int unsigned UW = 5;

    // Encoding order is the drain priority; NEXT relies on +1 stepping.
    typedef enum logic [1:0] {
        CH_F1,
        CH_F2,
        CH_S1,
        CH_S2
    } chanT;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        READ,
        NEXT
    } stateT;

endpackage

// File: rtl/orb_fifo_scheduler_if.sv
// Signal bundle between the orbit-RAM scheduler and its environment.
//   rq, sw                 : frame request and bank select (asynchronous levels)
//   usedw*, q*             : FIFO fill levels and normal-mode read data
//   sAddr1, sAddr2         : slow-word target addresses from the per-cycle ROM
//   rd*                    : FIFO read requests
//   wAddr, wData, we       : orbit-RAM write port
//   busy, ovr              : drain in progress / dropped-request pulse
// master = scheduler side, slave = FIFOs, framer and RAM side.
interface orb_fifo_scheduler_if;
    import orb_pkg::*;

    logic          rq;
    logic          sw;
    logic [UW-1:0] usedwF1;
    logic [UW-1:0] usedwF2;
    logic [UW-1:0] usedwS1;
    logic [UW-1:0] usedwS2;
    logic [DW-1:0] qF1;
    logic [DW-1:0] qF2;
    logic [DW-1:0] qS1;
    logic [DW-1:0] qS2;
    logic [AW-1:0] sAddr1;
    logic [AW-1:0] sAddr2;
    logic          rdF1;
    logic          rdF2;
    logic          rdS1;
    logic          rdS2;
    logic [AW-1:0] wAddr;
    logic [DW-1:0] wData;
    logic          we;
    logic          busy;
    logic          ovr;

    modport master (
        input  rq, sw,
        input  usedwF1, usedwF2, usedwS1, usedwS2,
        input  qF1, qF2, qS1, qS2,
        input  sAddr1, sAddr2,
        output rdF1, rdF2, rdS1, rdS2,
        output wAddr, wData, we,
        output busy, ovr
    );

    modport slave (
        output rq, sw,
        output usedwF1, usedwF2, usedwS1, usedwS2,
        output qF1, qF2, qS1, qS2,
        output sAddr1, sAddr2,
        input  rdF1, rdF2, rdS1, rdS2,
        input  wAddr, wData, we,
        input  busy, ovr
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by an edge detector.
//   clk80MHz : destination clock
//   rst      : asynchronous active-low reset
//   din      : asynchronous level input
//   pulse    : one-cycle pulse on a rising edge (ANY_EDGE = 0) or on either edge (ANY_EDGE = 1)
module sync_edge #(
    parameter bit ANY_EDGE = 1'b0
) (
    input  logic clk80MHz,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic metaQ;
    logic syncQ;
    logic prevQ;

    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            metaQ <= 1'b0;
            syncQ <= 1'b0;
            prevQ <= 1'b0;
        end else begin
            metaQ <= din;
            syncQ <= metaQ;
            prevQ <= syncQ;
        end
    end

    if (ANY_EDGE) begin : gAny
        assign pulse = syncQ ^ prevQ;
    end else begin : gRise
        assign pulse = syncQ & ~prevQ;
    end

endmodule

// File: rtl/orb_fifo_scheduler.sv
// Orbit-RAM write sequencer for the per-UART fast (F1, F2) and slow (S1, S2) FIFOs.
// On each frame request every FIFO holding a complete burst is drained in priority order
// F1, F2, S1, S2, producing one RAM write per word read. Fast bursts land in rotating slots
// per channel; the slot offsets restart whenever the ping-pong bank select toggles.
//   clk80MHz : system clock
//   rst      : asynchronous active-low reset
//   bus      : orb_fifo_scheduler_if master modport (FIFO, request and RAM signals)
module orb_fifo_scheduler
    import orb_pkg::*;
#(
    parameter int unsigned   FAST_WORDS = 16,
    parameter int unsigned   SLOW_WORDS = 1,
    parameter int unsigned   FAST_SLOTS = 4,
    parameter logic [AW-1:0] F1_BASE    = 11'd0,
    parameter logic [AW-1:0] F2_BASE    = 11'd64
) (
    input  logic                 clk80MHz,
    input  logic                 rst,
    orb_fifo_scheduler_if.master bus
);

    localparam int unsigned   OW         = (FAST_SLOTS > 1) ? $clog2(FAST_SLOTS) : 1;
    localparam logic [UW-1:0] FastLen    = UW'(FAST_WORDS);
    localparam logic [UW-1:0] SlowLen    = UW'(SLOW_WORDS);
    localparam logic [AW-1:0] FastStride = AW'(FAST_WORDS);

    function automatic logic [OW-1:0] nextSlot(input logic [OW-1:0] slot);
        return (slot == OW'(FAST_SLOTS - 1)) ? '0 : slot + 1'b1;
    endfunction

    // ---------------------------------------------------------------- synchronisers
    logic startEv;
    logic bankEv;

    sync_edge #(
        .ANY_EDGE (1'b0)
    ) uRqSync (
        .clk80MHz (clk80MHz),
        .rst      (rst),
        .din      (bus.rq),
        .pulse    (startEv)
    );

    sync_edge #(
        .ANY_EDGE (1'b1)
    ) uSwSync (
        .clk80MHz (clk80MHz),
        .rst      (rst),
        .din      (bus.sw),
        .pulse    (bankEv)
    );

    // ---------------------------------------------------------------- state
    stateT           stateQ, stateD;
    chanT            idxQ, idxD;
    logic [UW-1:0]   cntQ, cntD;
    logic [OW-1:0]   off1Q, off2Q;
    logic            clrPendQ;
    logic [AW-1:0]   slowBaseQ;
    logic            weQ;
    logic [AW-1:0]   wAddrQ;
    chanT            wChanQ;
    logic            busyQ;
    logic            ovrQ;

    logic            isFast;
    logic [UW-1:0]   burstLen;
    logic [UW-1:0]   usedwSel;
    logic            reading;
    logic            lastWord;
    logic            burstDone;
    logic            clrNow;
    logic [AW-1:0]   rdAddr;
    logic [DW-1:0]   wDataSel;

    assign isFast   = (idxQ == CH_F1) || (idxQ == CH_F2);
    assign burstLen = isFast ? FastLen : SlowLen;
    assign reading  = (stateQ == READ);
    assign lastWord = (cntQ == burstLen - 1'b1);
    assign burstDone = reading && lastWord;

    // A bank toggle seen mid-burst is held until the burst has finished so that the burst
    // stays in its original address sequence.
    assign clrNow = (bankEv || clrPendQ) && !reading;

    always_comb begin
        usedwSel = '0;
        unique case (idxQ)
            CH_F1: usedwSel = bus.usedwF1;
            CH_F2: usedwSel = bus.usedwF2;
            CH_S1: usedwSel = bus.usedwS1;
            CH_S2: usedwSel = bus.usedwS2;
            default: usedwSel = '0;
        endcase
    end

    // ---------------------------------------------------------------- sequencer
    always_comb begin
        stateD = stateQ;
        idxD   = idxQ;
        cntD   = cntQ;
        unique case (stateQ)
            IDLE: begin
                if (startEv) begin
                    stateD = CHECK;
                    idxD   = CH_F1;
                end
            end
            CHECK: begin
                // Only complete bursts are ever read.
                if (usedwSel >= burstLen) begin
                    stateD = READ;
                    cntD   = '0;
                end else begin
                    stateD = NEXT;
                end
            end
            READ: begin
                cntD = cntQ + 1'b1;
                if (lastWord) begin
                    stateD = NEXT;
                end
            end
            NEXT: begin
                if (idxQ == CH_S2) begin
                    stateD = IDLE;
                end else begin
                    idxD   = chanT'(idxQ + 2'd1);
                    stateD = CHECK;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- addressing
    always_comb begin
        rdAddr = '0;
        unique case (idxQ)
            CH_F1:   rdAddr = F1_BASE + AW'(off1Q) * FastStride + AW'(cntQ);
            CH_F2:   rdAddr = F2_BASE + AW'(off2Q) * FastStride + AW'(cntQ);
            CH_S1,
            CH_S2:   rdAddr = slowBaseQ + AW'(cntQ);
            default: rdAddr = '0;
        endcase
    end

    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            stateQ    <= IDLE;
            idxQ      <= CH_F1;
            cntQ      <= '0;
            off1Q     <= '0;
            off2Q     <= '0;
            clrPendQ  <= 1'b0;
            slowBaseQ <= '0;
            weQ       <= 1'b0;
            wAddrQ    <= '0;
            wChanQ    <= CH_F1;
            busyQ     <= 1'b0;
            ovrQ      <= 1'b0;
        end else begin
            stateQ <= stateD;
            idxQ   <= idxD;
            cntQ   <= cntD;

            if ((stateQ == CHECK) && (stateD == READ)) begin
                slowBaseQ <= (idxQ == CH_S1) ? bus.sAddr1 : bus.sAddr2;
            end

            clrPendQ <= reading && (bankEv || clrPendQ);
            if (clrNow) begin
                off1Q <= '0;
                off2Q <= '0;
            end else if (burstDone) begin
                if (idxQ == CH_F1) off1Q <= nextSlot(off1Q);
                if (idxQ == CH_F2) off2Q <= nextSlot(off2Q);
            end

            // One write per word, issued the cycle after its rd* when q is valid.
            weQ    <= reading;
            wChanQ <= idxQ;
            if (reading) begin
                wAddrQ <= rdAddr;
            end

            // Stays high through the final write, which issues during the last NEXT.
            busyQ <= (stateD != IDLE);
            ovrQ  <= startEv && (stateQ != IDLE);
        end
    end

    // FIFO q is valid during the write cycle, so data is taken straight from it.
    always_comb begin
        wDataSel = '0;
        unique case (wChanQ)
            CH_F1:   wDataSel = bus.qF1;
            CH_F2:   wDataSel = bus.qF2;
            CH_S1:   wDataSel = bus.qS1;
            CH_S2:   wDataSel = bus.qS2;
            default: wDataSel = '0;
        endcase
    end

    assign bus.rdF1  = reading && (idxQ == CH_F1);
    assign bus.rdF2  = reading && (idxQ == CH_F2);
    assign bus.rdS1  = reading && (idxQ == CH_S1);
    assign bus.rdS2  = reading && (idxQ == CH_S2);
    assign bus.we    = weQ;
    assign bus.wAddr = wAddrQ;
    assign bus.wData = weQ ? wDataSel : '0;
    assign bus.busy  = busyQ;
    assign bus.ovr   = ovrQ;

endmodule

// File: tb/tb_orb_fifo_scheduler.sv
// Directed self-checking bench for orb_fifo_scheduler. FIFO channel c (0=F1..3=S2) returns
// 0x100*(c+1) + n on its n-th read; every RAM write is logged and compared with a hand-built
// list of {address, data}.
module tb_orb_fifo_scheduler;
    import orb_pkg::*;

    logic clk80MHz = 1'b0;
    logic rst      = 1'b0;

    always #6 clk80MHz = ~clk80MHz;

    orb_fifo_scheduler_if bus ();

    orb_fifo_scheduler dut (
        .clk80MHz (clk80MHz),
        .rst      (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Monitor state (owned by the monitor/model processes, cleared while rst is low).
    logic [3:0]         rdLat;
    int                 qCnt [4];
    int                 rdCnt [4];
    int                 ovrCnt;
    int                 oneHotViol;
    int                 weViol;
    int                 weNoBusy;
    logic [AW+DW-1:0]   gotQ [$];

    // Expected-value state (owned by the initial block).
    logic [AW+DW-1:0]   expQ [$];
    int                 expCnt [4];

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: normal mode, data appears the cycle after rdreq.
    always @(posedge clk80MHz) begin
        if (!rst) begin
            qCnt    <= '{default: 0};
            bus.qF1 <= '0;
            bus.qF2 <= '0;
            bus.qS1 <= '0;
            bus.qS2 <= '0;
        end else begin
            if (rdLat[0]) begin bus.qF1 <= DW'(12'h100 + qCnt[0]); qCnt[0] <= qCnt[0] + 1; end
            if (rdLat[1]) begin bus.qF2 <= DW'(12'h200 + qCnt[1]); qCnt[1] <= qCnt[1] + 1; end
            if (rdLat[2]) begin bus.qS1 <= DW'(12'h300 + qCnt[2]); qCnt[2] <= qCnt[2] + 1; end
            if (rdLat[3]) begin bus.qS2 <= DW'(12'h400 + qCnt[3]); qCnt[3] <= qCnt[3] + 1; end
        end
    end

    // Write logger and protocol watchers, sampled mid-cycle.
    always @(negedge clk80MHz) begin
        logic [3:0] rdNow;
        rdNow = {bus.rdS2, bus.rdS1, bus.rdF2, bus.rdF1};
        if (!rst) begin
            gotQ.delete();
            rdCnt      = '{default: 0};
            ovrCnt     = 0;
            oneHotViol = 0;
            weViol     = 0;
            weNoBusy   = 0;
        end else begin
            if ($countones(rdNow) > 1) oneHotViol++;
            if (bus.we && (rdLat == 4'b0)) weViol++;
            if (bus.we && !bus.busy) weNoBusy++;
            if (bus.we) gotQ.push_back({bus.wAddr, bus.wData});
            if (bus.ovr) ovrCnt++;
            for (int c = 0; c < 4; c++) if (rdNow[c]) rdCnt[c]++;
        end
        rdLat <= rdNow;
    end

    task automatic setUsed(input int f1, input int f2, input int s1, input int s2);
        bus.usedwF1 = UW'(f1);
        bus.usedwF2 = UW'(f2);
        bus.usedwS1 = UW'(s1);
        bus.usedwS2 = UW'(s2);
    endtask

    task automatic doReset();
        rst    = 1'b0;
        bus.rq = 1'b0;
        repeat (3) @(posedge clk80MHz);
        #1 rst = 1'b1;
        expQ.delete();
        expCnt = '{default: 0};
        repeat (2) @(negedge clk80MHz);
    endtask

    task automatic expBurst(input int ch, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            expQ.push_back({AW'(base + i), DW'(256 * (ch + 1) + expCnt[ch])});
            expCnt[ch]++;
        end
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            @(negedge clk80MHz);
            n++;
        end
        checkVal({tag, ".idle"}, int'(bus.busy), 0);
        repeat (4) @(negedge clk80MHz);
    endtask

    task automatic runFrame(input string tag);
        int n;
        n = 0;
        bus.rq = 1'b1;
        while (!bus.busy && n < 10) begin
            @(negedge clk80MHz);
            n++;
        end
        checkVal({tag, ".busy"}, int'(bus.busy), 1);
        bus.rq = 1'b0;
        waitIdle(tag);
    endtask

    task automatic waitRd(input string tag, input int ch);
        int n;
        n = 0;
        while (!rdLat[ch] && n < 40) begin
            @(negedge clk80MHz);
            n++;
        end
        checkVal({tag, ".rdSeen"}, int'(rdLat[ch]), 1);
    endtask

    task automatic compareWrites(input string tag);
        checkVal({tag, ".count"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkVal($sformatf("%s.wr%0d", tag, i), int'(gotQ[i]), int'(expQ[i]));
        end
        checkVal({tag, ".oneRd"}, oneHotViol, 0);
        checkVal({tag, ".weNoRd"}, weViol, 0);
        checkVal({tag, ".weNoBusy"}, weNoBusy, 0);
    endtask

    initial begin
        int n;
        bus.rq     = 1'b0;
        bus.sw     = 1'b0;
        bus.sAddr1 = 11'h200;
        bus.sAddr2 = 11'h300;
        setUsed(0, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk80MHz);
        checkVal("rst.rd", int'({bus.rdF1, bus.rdF2, bus.rdS1, bus.rdS2}), 0);
        checkVal("rst.we", int'(bus.we), 0);
        checkVal("rst.busy", int'(bus.busy), 0);
        checkVal("rst.ovr", int'(bus.ovr), 0);
        checkVal("rst.wAddr", int'(bus.wAddr), 0);
        checkVal("rst.wData", int'(bus.wData), 0);

        // A: single F1 burst, start latency
        doReset();
        setUsed(16, 0, 0, 0);
        bus.rq = 1'b1;
        n = 0;
        do begin
            @(negedge clk80MHz);
            n++;
        end while (!bus.rdF1 && n < 10);
        checkVal("A.latency<=5", int'(n <= 5), 1);
        bus.rq = 1'b0;
        waitIdle("A");
        expBurst(0, 0, 16);
        checkVal("A.rdF1", rdCnt[0], 16);
        compareWrites("A");

        // B: F1, F2, S1 full; S2 empty
        doReset();
        setUsed(16, 16, 1, 0);
        runFrame("B");
        expBurst(0, 0, 16);
        expBurst(1, 64, 16);
        expBurst(2, 12'h200, 1);
        checkVal("B.rdS2", rdCnt[3], 0);
        compareWrites("B");

        // C: partial F1 burst is skipped and leaves the offset alone
        doReset();
        setUsed(15, 0, 0, 0);
        runFrame("C1");
        checkVal("C.noRdF1", rdCnt[0], 0);
        setUsed(16, 0, 0, 0);
        runFrame("C2");
        expBurst(0, 0, 16);
        compareWrites("C");

        // D: F1 slot rotation and wrap
        doReset();
        setUsed(16, 0, 0, 0);
        for (int f = 0; f < 5; f++) begin
            runFrame($sformatf("D%0d", f));
            expBurst(0, 16 * (f % 4), 16);
        end
        compareWrites("D");

        // E: bank toggle mid-burst, while idle, and together with a start event
        doReset();
        setUsed(0, 16, 0, 0);
        runFrame("E1");
        runFrame("E2");
        bus.rq = 1'b1;
        waitRd("E3", 1);
        bus.rq = 1'b0;
        repeat (3) @(negedge clk80MHz);
        bus.sw = ~bus.sw;
        waitIdle("E3");
        runFrame("E4");
        expBurst(1, 64, 16);
        expBurst(1, 80, 16);
        expBurst(1, 96, 16);
        expBurst(1, 64, 16);
        bus.sw = ~bus.sw;
        repeat (6) @(negedge clk80MHz);
        runFrame("E5");
        expBurst(1, 64, 16);
        bus.sw = ~bus.sw;
        runFrame("E6");
        expBurst(1, 64, 16);
        compareWrites("E");

        // F: second request while busy is dropped with an ovr pulse
        doReset();
        setUsed(16, 0, 0, 0);
        bus.rq = 1'b1;
        waitRd("F", 0);
        bus.rq = 1'b0;
        repeat (2) @(negedge clk80MHz);
        bus.rq = 1'b1;
        repeat (4) @(negedge clk80MHz);
        bus.rq = 1'b0;
        waitIdle("F");
        expBurst(0, 0, 16);
        checkVal("F.ovr", ovrCnt, 1);
        checkVal("F.rdF1", rdCnt[0], 16);
        compareWrites("F");

        // G: reset in the middle of a burst
        doReset();
        setUsed(16, 0, 0, 0);
        runFrame("G0");
        bus.rq = 1'b1;
        waitRd("G", 0);
        bus.rq = 1'b0;
        repeat (3) @(negedge clk80MHz);
        rst = 1'b0;
        #1;
        checkVal("G.rdDrop", int'({bus.rdF1, bus.rdF2, bus.rdS1, bus.rdS2}), 0);
        checkVal("G.weDrop", int'(bus.we), 0);
        checkVal("G.busyDrop", int'(bus.busy), 0);
        repeat (2) @(posedge clk80MHz);
        #1 rst = 1'b1;
        expQ.delete();
        expCnt = '{default: 0};
        repeat (2) @(negedge clk80MHz);
        runFrame("G1");
        expBurst(0, 0, 16);
        compareWrites("G");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/orb_fifo_scheduler.md
Name: orb_fifo_scheduler

Overview:
- Sequences all orbit-RAM writes from the per-UART fast and slow FIFOs (F1, F2, S1, S2) in the clk80MHz domain.
- On each frame request from the M16 framer, it drains every FIFO holding a complete burst, in fixed priority order.
- For each word it produces the RAM write address, data and write strobe; the ping-pong demux downstream uses these.
- It tracks the ping-pong bank select so that fast-slot offsets restart in each new bank.

Parameters:
- DW, 12, word width
- AW, 11, RAM address width
- UW, 5, FIFO usedw width
- FAST_WORDS, 16, words per fast burst
- SLOW_WORDS, 1, words per slow burst
- FAST_SLOTS, 4, fast bursts per channel per bank; offset wraps at this count
- F1_BASE, 11'd0, first fast address for channel 1
- F2_BASE, 11'd64, first fast address for channel 2

Ports:
- clk80MHz  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rq  in  1  frame request (RqFast) from the clkOrb domain; level, asynchronous to this clock
- sw  in  1  ping-pong bank select from M16, asynchronous to this clock
- usedwF1, usedwF2, usedwS1, usedwS2  in  UW each  FIFO fill levels
- qF1, qF2, qS1, qS2  in  DW each  FIFO outputs; normal mode, valid 1 cycle after rdreq
- sAddr1, sAddr2  in  AW each  slow target address from the per-cycle ROM
- rdF1, rdF2, rdS1, rdS2  out  1 each  FIFO read requests
- wAddr  out  AW  RAM write address
- wData  out  DW  RAM write data
- we  out  1  RAM write enable
- busy  out  1  a drain sequence is in progress
- ovr  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset: all outputs 0, state IDLE, both fast offsets 0, synchroniser flops 0.
- rq and sw each pass through a 2-flop synchroniser.
- A start event is a rising edge of synchronised rq. A bank toggle is any edge of synchronised sw.
- States: IDLE, CHECK, READ, NEXT.
- IDLE:
  - A start event moves to CHECK with index = F1 and sets busy = 1.
  - Start-event latency: edge on rq to first rd* is at most 5 cycles.
- CHECK:
  - Burst size is FAST_WORDS for F-channels and SLOW_WORDS for S-channels.
  - If usedw of the indexed FIFO >= burst size, go to READ with word counter = 0.
  - Otherwise skip the FIFO and go to NEXT. No partial bursts are ever read.
- READ:
  - Assert the indexed rd* for exactly the burst size in consecutive cycles.
  - Go to NEXT after the last rd*.
- NEXT:
  - Advance index F1 -> F2 -> S1 -> S2.
  - After S2, return to IDLE and set busy = 0.
- Write pipeline (registered, 1 cycle after each rd*):
  - we = 1; wData = q of the FIFO read; wAddr from the address rules below.
  - The last write completes 1 cycle after the last rd*. busy stays high until that write has issued.
- Address rules:
  - Fast k: wAddr = Fk_BASE + offk*FAST_WORDS + word counter.
  - offk increments (mod FAST_SLOTS) when a burst on channel k completes.
  - Slow k: wAddr = sAddrk + word counter. sAddrk is sampled at entry to READ.
  - All address sums are truncated to AW bits.
- Bank toggle:
  - While idle, both offsets clear to 0 on the next cycle.
  - During a burst, the clear is deferred until the burst ends. The current burst finishes in the old address sequence.
- Start event while busy: the request is ignored and ovr pulses for 1 cycle.
- Simultaneous start event and bank toggle in IDLE: apply the offset clear first; the sequence then uses offset 0.
- Only one rd* is high at any cycle. we is never high without a matching rd* 1 cycle earlier.

Decomposition:
- Shared package orb_pkg:
  - DW, AW and UW constants
  - channel index enum: CH_F1, CH_F2, CH_S1, CH_S2
  - state enum
- Sub-module sync_edge: 2-flop synchroniser plus rise/any-edge detect. Instanced twice, for rq and sw.

Test Plan:
- Reset; usedwF1 = 16, others 0; pulse rq:
  - rdF1 high 16 cycles.
  - we follows with wAddr 0..15 and wData equal to qF1 per cycle.
  - busy falls after the last write.
- usedwF1 = usedwF2 = 16, usedwS1 = 1, usedwS2 = 0; pulse rq:
  - Order is F1 (0..15), F2 (64..79), S1 (1 write at sAddr1 = 11'h200).
  - S2 produces no rdS2.
- usedwF1 = 15; rq -> no rdF1, no we; F1 offset unchanged.
- Four rq frames with F1 full each time -> F1 burst bases 0, 16, 32, 48; fifth frame -> base 0 (offset wraps).
- Toggle sw in the middle of an F2 burst at offset 2 -> current burst finishes at 96..111; next frame F2 base = 64.
- Second rq edge while busy -> ovr pulses 1 cycle; no extra rd*; current sequence unaffected.
- Assert rst low during READ -> all rd*/we drop to 0 immediately; after release the block is in IDLE with offsets 0.
